// File: rtl/regfile_pkg.sv
// Shared types, default sizes and the lane-priority write resolution
// used by the parallel register file.
package regfile_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_DATA_WIDTH = 32;
  localparam int PARALLEL_ORDER = 2;
  localparam int MAX_LANES      = 32;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [REG_DATA_WIDTH-1:0] reg_data_t;
  typedef logic [MAX_LANES-1:0]      lane_mask_t;

  // A lane owns an address when it hits it and no higher-indexed lane does.
  function automatic logic lane_wins(input lane_mask_t hits, input int lane);
    lane_mask_t higher;
    higher = hits >> (lane + 1);
    return hits[lane] && (higher == '0);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set by reservations and
// cleared by committed writes, with reservations taking precedence.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_LANES  = PARALLEL_ORDER,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_LANES-1:0]                 set_valid,
  input  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] set_addr,
  input  logic [NUM_LANES-1:0]                 clr_valid,
  input  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] clr_addr,
  output logic [2**ADDR_WIDTH-1:0]             busy
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DEPTH-1:0] busy_nxt;

  // Clears are applied first so a same-cycle reservation keeps the bit set.
  always_comb begin
    busy_nxt = busy;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (clr_valid[i]) busy_nxt[clr_addr[i]] = 1'b0;
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      if (set_valid[i]) busy_nxt[set_addr[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

endmodule

// File: rtl/par_regfile_sb.sv
// Multi-lane flop register file with registered reads and a busy scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to reads.
module par_regfile_sb
  import regfile_pkg::*;
#(
  parameter int NUM_LANES  = PARALLEL_ORDER,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter int DATA_WIDTH = REG_DATA_WIDTH,
  parameter int ZERO_REG0  = 0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_LANES-1:0]                 r_valid1,
  input  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] r_addr1,
  input  logic [NUM_LANES-1:0]                 r_valid2,
  input  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] r_addr2,
  input  logic [NUM_LANES-1:0]                 w_valid,
  input  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] w_addr,
  input  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] w_data,
  input  logic [NUM_LANES-1:0]                 rsv_valid,
  input  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] rsv_addr,
  output logic [NUM_LANES-1:0]                 rd_valid1,
  output logic [NUM_LANES-1:0][DATA_WIDTH-1:0] rd_data1,
  output logic [NUM_LANES-1:0]                 rd_busy1,
  output logic [NUM_LANES-1:0]                 rd_valid2,
  output logic [NUM_LANES-1:0][DATA_WIDTH-1:0] rd_data2,
  output logic [NUM_LANES-1:0]                 rd_busy2,
  output logic [2**ADDR_WIDTH-1:0]             busy
);

  localparam int DEPTH  = 2**ADDR_WIDTH;
  localparam int NPORTS = 2 * NUM_LANES;

  logic [NUM_LANES-1:0]  w_eff;
  logic [NUM_LANES-1:0]  rsv_eff;
  logic [NUM_LANES-1:0]  w_commit;
  logic [DATA_WIDTH-1:0] regs [DEPTH];

  logic [NPORTS-1:0]     rp_req;
  logic [ADDR_WIDTH-1:0] rp_addr   [NPORTS];
  logic [DATA_WIDTH-1:0] rdata_nxt [NPORTS];
  logic [NPORTS-1:0]     rbusy_nxt;
  logic [NPORTS-1:0]     rd_valid_q;
  logic [NPORTS-1:0]     rd_busy_q;
  logic [DATA_WIDTH-1:0] rd_data_q [NPORTS];

  // Register 0 optionally behaves as a hard zero: its writes and reserves vanish here.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      w_eff[i]   = w_valid[i]   && !((ZERO_REG0 != 0) && (w_addr[i]   == '0));
      rsv_eff[i] = rsv_valid[i] && !((ZERO_REG0 != 0) && (rsv_addr[i] == '0));
    end
  end

  always_comb begin : commit_sel
    lane_mask_t hits;
    for (int i = 0; i < NUM_LANES; i++) begin
      hits = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
        hits[k] = w_eff[k] && (w_addr[k] == w_addr[i]);
      end
      w_commit[i] = lane_wins(hits, i);
    end
  end

  regfile_scoreboard #(
    .NUM_LANES (NUM_LANES),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_valid(rsv_eff),
    .set_addr (rsv_addr),
    .clr_valid(w_eff),
    .clr_addr (w_addr),
    .busy     (busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (w_commit[i]) regs[w_addr[i]] <= w_data[i];
      end
    end
  end

  // Both read ports of every lane are flattened into one port list.
  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      rp_req[l]              = r_valid1[l];
      rp_req[NUM_LANES + l]  = r_valid2[l];
      rp_addr[l]             = r_addr1[l];
      rp_addr[NUM_LANES + l] = r_addr2[l];
    end
  end

  always_comb begin : read_sel
`ifdef REGFILE_BYPASS_EN
    lane_mask_t hits;
`endif
    for (int p = 0; p < NPORTS; p++) begin
      rdata_nxt[p] = regs[rp_addr[p]];
      rbusy_nxt[p] = busy[rp_addr[p]];
`ifdef REGFILE_BYPASS_EN
      hits = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
        hits[k] = w_eff[k] && (w_addr[k] == rp_addr[p]);
      end
      for (int k = 0; k < NUM_LANES; k++) begin
        if (lane_wins(hits, k)) begin
          rdata_nxt[p] = w_data[k];
          rbusy_nxt[p] = 1'b0;
        end
      end
`endif
    end
  end

  // Data and busy flag hold their last value while a port is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= '0;
      rd_busy_q  <= '0;
      for (int p = 0; p < NPORTS; p++) rd_data_q[p] <= '0;
    end else begin
      rd_valid_q <= rp_req;
      for (int p = 0; p < NPORTS; p++) begin
        if (rp_req[p]) begin
          rd_data_q[p] <= rdata_nxt[p];
          rd_busy_q[p] <= rbusy_nxt[p];
        end
      end
    end
  end

  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      rd_valid1[l] = rd_valid_q[l];
      rd_busy1[l]  = rd_busy_q[l];
      rd_data1[l]  = rd_data_q[l];
      rd_valid2[l] = rd_valid_q[NUM_LANES + l];
      rd_busy2[l]  = rd_busy_q[NUM_LANES + l];
      rd_data2[l]  = rd_data_q[NUM_LANES + l];
    end
  end

endmodule

// File: tb/tb_par_regfile_sb.sv
// Bench for par_regfile_sb: a default instance and a ZERO_REG0 instance share
// stimulus; directed vectors, random traffic and a mid-operation reset.
module tb_par_regfile_sb;

  localparam int NL    = 2;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int NTBL  = 16;

  typedef enum logic [1:0] {CHK_NONE, CHK_READ, CHK_BUSY} chk_kind_t;

  typedef struct {
    logic [NL-1:0]         w_valid;
    logic [NL-1:0][AW-1:0] w_addr;
    logic [NL-1:0][DW-1:0] w_data;
    logic [NL-1:0]         r_valid1;
    logic [NL-1:0][AW-1:0] r_addr1;
    logic [NL-1:0]         r_valid2;
    logic [NL-1:0][AW-1:0] r_addr2;
    logic [NL-1:0]         rsv_valid;
    logic [NL-1:0][AW-1:0] rsv_addr;
    chk_kind_t             kind;
    int                    dut;
    int                    lane;
    int                    port;
    logic [AW-1:0]         addr;
    logic [DW-1:0]         exp_data;
    logic                  exp_valid;
    logic                  exp_bit;
  } vec_t;

  logic clk;
  logic rst_n;
  logic [NL-1:0]         r_valid1, r_valid2, w_valid, rsv_valid;
  logic [NL-1:0][AW-1:0] r_addr1, r_addr2, w_addr, rsv_addr;
  logic [NL-1:0][DW-1:0] w_data;

  logic [NL-1:0]         rd_valid1 [2];
  logic [NL-1:0]         rd_valid2 [2];
  logic [NL-1:0]         rd_busy1  [2];
  logic [NL-1:0]         rd_busy2  [2];
  logic [NL-1:0][DW-1:0] rd_data1  [2];
  logic [NL-1:0][DW-1:0] rd_data2  [2];
  logic [DEPTH-1:0]      busy      [2];

  logic [DW-1:0]    m_regs  [2][DEPTH];
  logic [DEPTH-1:0] m_busy  [2];
  logic             e_valid [2][2][NL];
  logic [DW-1:0]    e_data  [2][2][NL];
  logic             e_rbusy [2][2][NL];

  vec_t tbl [NTBL];
  int   n_vec;
  int   n_err;

  par_regfile_sb #(.NUM_LANES(NL), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ZERO_REG0(0)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .r_valid1(r_valid1), .r_addr1(r_addr1), .r_valid2(r_valid2), .r_addr2(r_addr2),
    .w_valid(w_valid), .w_addr(w_addr), .w_data(w_data),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .rd_valid1(rd_valid1[0]), .rd_data1(rd_data1[0]), .rd_busy1(rd_busy1[0]),
    .rd_valid2(rd_valid2[0]), .rd_data2(rd_data2[0]), .rd_busy2(rd_busy2[0]),
    .busy(busy[0])
  );

  par_regfile_sb #(.NUM_LANES(NL), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ZERO_REG0(1)) dut_z (
    .clk(clk), .rst_n(rst_n),
    .r_valid1(r_valid1), .r_addr1(r_addr1), .r_valid2(r_valid2), .r_addr2(r_addr2),
    .w_valid(w_valid), .w_addr(w_addr), .w_data(w_data),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .rd_valid1(rd_valid1[1]), .rd_data1(rd_data1[1]), .rd_busy1(rd_busy1[1]),
    .rd_valid2(rd_valid2[1]), .rd_data2(rd_data2[1]), .rd_busy2(rd_busy2[1]),
    .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t idle_vec();
    vec_t v;
    v.w_valid = '0;   v.w_addr = '0;   v.w_data = '0;
    v.r_valid1 = '0;  v.r_addr1 = '0;
    v.r_valid2 = '0;  v.r_addr2 = '0;
    v.rsv_valid = '0; v.rsv_addr = '0;
    v.kind = CHK_NONE; v.dut = 0; v.lane = 0; v.port = 0; v.addr = '0;
    v.exp_data = '0; v.exp_valid = 1'b0; v.exp_bit = 1'b0;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = '0;
      for (int r = 0; r < DEPTH; r++) m_regs[d][r] = '0;
      for (int p = 0; p < 2; p++) begin
        for (int l = 0; l < NL; l++) begin
          e_valid[d][p][l] = 1'b0;
          e_data[d][p][l]  = '0;
          e_rbusy[d][p][l] = 1'b0;
        end
      end
    end
  endtask

  // Reference behaviour: reads see the pre-edge state (or the winning write
  // when forwarding is built in); then writes commit, then reservations land.
  task automatic model_step();
    logic          zero, req, b;
    logic [AW-1:0] a;
    logic [DW-1:0] v;
    for (int d = 0; d < 2; d++) begin
      zero = (d == 1);
      for (int p = 0; p < 2; p++) begin
        for (int l = 0; l < NL; l++) begin
          req = (p == 0) ? r_valid1[l] : r_valid2[l];
          a   = (p == 0) ? r_addr1[l]  : r_addr2[l];
          e_valid[d][p][l] = req;
          if (req) begin
            v = m_regs[d][a];
            b = m_busy[d][a];
`ifdef REGFILE_BYPASS_EN
            for (int k = 0; k < NL; k++) begin
              if (w_valid[k] && w_addr[k] == a && !(zero && a == 0)) begin
                v = w_data[k];
                b = 1'b0;
              end
            end
`endif
            e_data[d][p][l]  = v;
            e_rbusy[d][p][l] = b;
          end
        end
      end
      for (int k = 0; k < NL; k++) begin
        if (w_valid[k] && !(zero && w_addr[k] == 0)) begin
          m_regs[d][w_addr[k]] = w_data[k];
          m_busy[d][w_addr[k]] = 1'b0;
        end
      end
      for (int k = 0; k < NL; k++) begin
        if (rsv_valid[k] && !(zero && rsv_addr[k] == 0)) m_busy[d][rsv_addr[k]] = 1'b1;
      end
    end
  endtask

  function automatic logic [DW-1:0] get_data(input int d, input int p, input int l);
    return (p == 0) ? rd_data1[d][l] : rd_data2[d][l];
  endfunction

  function automatic logic get_valid(input int d, input int p, input int l);
    return (p == 0) ? rd_valid1[d][l] : rd_valid2[d][l];
  endfunction

  function automatic logic get_rbusy(input int d, input int p, input int l);
    return (p == 0) ? rd_busy1[d][l] : rd_busy2[d][l];
  endfunction

  task automatic check_output();
    for (int d = 0; d < 2; d++) begin
      cmp($sformatf("busy dut%0d", d), busy[d], m_busy[d]);
      for (int p = 0; p < 2; p++) begin
        for (int l = 0; l < NL; l++) begin
          cmp($sformatf("rd_valid%0d dut%0d lane%0d", p + 1, d, l),
              {31'd0, get_valid(d, p, l)}, {31'd0, e_valid[d][p][l]});
          cmp($sformatf("rd_data%0d dut%0d lane%0d", p + 1, d, l),
              get_data(d, p, l), e_data[d][p][l]);
          cmp($sformatf("rd_busy%0d dut%0d lane%0d", p + 1, d, l),
              {31'd0, get_rbusy(d, p, l)}, {31'd0, e_rbusy[d][p][l]});
        end
      end
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    w_valid = v.w_valid;     w_addr = v.w_addr;     w_data = v.w_data;
    r_valid1 = v.r_valid1;   r_addr1 = v.r_addr1;
    r_valid2 = v.r_valid2;   r_addr2 = v.r_addr2;
    rsv_valid = v.rsv_valid; rsv_addr = v.rsv_addr;
    model_step();
    @(posedge clk);
    #1;
    check_output();
  endtask

  task automatic check_row(input int idx, input vec_t v);
    case (v.kind)
      CHK_READ: begin
        cmp($sformatf("row%0d data", idx), get_data(v.dut, v.port, v.lane), v.exp_data);
        cmp($sformatf("row%0d valid", idx), {31'd0, get_valid(v.dut, v.port, v.lane)},
            {31'd0, v.exp_valid});
        cmp($sformatf("row%0d rd_busy", idx), {31'd0, get_rbusy(v.dut, v.port, v.lane)},
            {31'd0, v.exp_bit});
      end
      CHK_BUSY: cmp($sformatf("row%0d busy bit", idx), {31'd0, busy[v.dut][v.addr]},
                    {31'd0, v.exp_bit});
      default: ;
    endcase
  endtask

  task automatic fill_table();
    vec_t t;
    t = idle_vec(); t.w_valid = 2'b11;
    t.w_addr[0] = 5'd1; t.w_data[0] = 32'h40A00000;
    t.w_addr[1] = 5'd2; t.w_data[1] = 32'h40800000;
    t.kind = CHK_BUSY; t.addr = 5'd1; t.exp_bit = 1'b0; tbl[0] = t;

    t = idle_vec(); t.r_valid1[1] = 1'b1; t.r_addr1[1] = 5'd1;
    t.r_valid2[1] = 1'b1; t.r_addr2[1] = 5'd2;
    t.kind = CHK_READ; t.lane = 1; t.port = 0; t.exp_data = 32'h40A00000;
    t.exp_valid = 1'b1; tbl[1] = t;

    t = idle_vec(); t.kind = CHK_READ; t.lane = 1; t.port = 1;
    t.exp_data = 32'h40800000; t.exp_valid = 1'b0; tbl[2] = t;

    t = idle_vec(); t.w_valid = 2'b11;
    t.w_addr[0] = 5'd5; t.w_data[0] = 32'h11111111;
    t.w_addr[1] = 5'd5; t.w_data[1] = 32'h22222222;
    t.kind = CHK_BUSY; t.addr = 5'd5; tbl[3] = t;

    t = idle_vec(); t.r_valid2[0] = 1'b1; t.r_addr2[0] = 5'd5;
    t.kind = CHK_READ; t.lane = 0; t.port = 1; t.exp_data = 32'h22222222;
    t.exp_valid = 1'b1; tbl[4] = t;

    t = idle_vec(); t.w_valid[1] = 1'b1; t.w_addr[1] = 5'd3; t.w_data[1] = 32'h41100000;
    t.r_valid1[0] = 1'b1; t.r_addr1[0] = 5'd3;
    t.kind = CHK_READ; t.lane = 0; t.port = 0; t.exp_valid = 1'b1;
`ifdef REGFILE_BYPASS_EN
    t.exp_data = 32'h41100000;
`else
    t.exp_data = 32'h00000000;
`endif
    tbl[5] = t;

    t = idle_vec(); t.rsv_valid[1] = 1'b1; t.rsv_addr[1] = 5'd3;
    t.kind = CHK_BUSY; t.addr = 5'd3; t.exp_bit = 1'b1; tbl[6] = t;

    t = idle_vec(); t.r_valid1[0] = 1'b1; t.r_addr1[0] = 5'd3;
    t.kind = CHK_READ; t.exp_data = 32'h41100000; t.exp_valid = 1'b1;
    t.exp_bit = 1'b1; tbl[7] = t;

    t = idle_vec(); t.w_valid[0] = 1'b1; t.w_addr[0] = 5'd3; t.w_data[0] = 32'h3F800000;
    t.kind = CHK_BUSY; t.addr = 5'd3; t.exp_bit = 1'b0; tbl[8] = t;

    t = idle_vec(); t.r_valid1[0] = 1'b1; t.r_addr1[0] = 5'd3;
    t.kind = CHK_READ; t.exp_data = 32'h3F800000; t.exp_valid = 1'b1; tbl[9] = t;

    t = idle_vec(); t.w_valid[0] = 1'b1; t.w_addr[0] = 5'd4; t.w_data[0] = 32'h00000001;
    t.rsv_valid[1] = 1'b1; t.rsv_addr[1] = 5'd4;
    t.kind = CHK_BUSY; t.addr = 5'd4; t.exp_bit = 1'b1; tbl[10] = t;

    t = idle_vec(); t.rsv_valid[1] = 1'b1; t.rsv_addr[1] = 5'd3;
    t.kind = CHK_BUSY; t.addr = 5'd3; t.exp_bit = 1'b1; tbl[11] = t;

    t = idle_vec(); t.w_valid[1] = 1'b1; t.w_addr[1] = 5'd3; t.w_data[1] = 32'h40400000;
    t.r_valid1[0] = 1'b1; t.r_addr1[0] = 5'd3;
    t.kind = CHK_READ; t.exp_valid = 1'b1;
`ifdef REGFILE_BYPASS_EN
    t.exp_data = 32'h40400000; t.exp_bit = 1'b0;
`else
    t.exp_data = 32'h3F800000; t.exp_bit = 1'b1;
`endif
    tbl[12] = t;

    t = idle_vec(); t.w_valid[0] = 1'b1; t.w_addr[0] = 5'd0; t.w_data[0] = 32'hDEADBEEF;
    t.rsv_valid[1] = 1'b1; t.rsv_addr[1] = 5'd0;
    t.kind = CHK_BUSY; t.dut = 1; t.addr = 5'd0; t.exp_bit = 1'b0; tbl[13] = t;

    t = idle_vec(); t.r_valid1[0] = 1'b1; t.r_addr1[0] = 5'd0;
    t.kind = CHK_READ; t.dut = 1; t.exp_data = 32'h0; t.exp_valid = 1'b1;
    t.exp_bit = 1'b0; tbl[14] = t;

    t = idle_vec(); t.kind = CHK_BUSY; t.dut = 0; t.addr = 5'd0; t.exp_bit = 1'b1;
    tbl[15] = t;
  endtask

  initial begin
    vec_t v;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    v = idle_vec();
    w_valid = '0; w_addr = '0; w_data = '0;
    r_valid1 = '0; r_addr1 = '0; r_valid2 = '0; r_addr2 = '0;
    rsv_valid = '0; rsv_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_output();
    rst_n = 1'b1;

    fill_table();
    for (int i = 0; i < NTBL; i++) begin
      apply_stimulus(tbl[i]);
      check_row(i, tbl[i]);
    end

    // Random traffic over a narrow address window to provoke conflicts.
    for (int n = 0; n < 400; n++) begin
      v = idle_vec();
      for (int l = 0; l < NL; l++) begin
        v.w_valid[l]   = ($urandom_range(0, 2) == 0);
        v.w_addr[l]    = AW'($urandom_range(0, 7));
        v.w_data[l]    = $urandom;
        v.r_valid1[l]  = ($urandom_range(0, 1) == 0);
        v.r_addr1[l]   = AW'($urandom_range(0, 7));
        v.r_valid2[l]  = ($urandom_range(0, 1) == 0);
        v.r_addr2[l]   = AW'($urandom_range(0, 7));
        v.rsv_valid[l] = ($urandom_range(0, 3) == 0);
        v.rsv_addr[l]  = AW'($urandom_range(0, 7));
      end
      apply_stimulus(v);
    end

    // Mid-operation reset: load r1, issue reads and a reserve, then drop rst_n.
    v = idle_vec(); v.w_valid[0] = 1'b1; v.w_addr[0] = 5'd1; v.w_data[0] = 32'h12345678;
    apply_stimulus(v);
    v = idle_vec(); v.r_valid1[0] = 1'b1; v.r_addr1[0] = 5'd1;
    v.r_valid2[1] = 1'b1; v.r_addr2[1] = 5'd1;
    apply_stimulus(v);
    v = idle_vec(); v.r_valid1 = 2'b11; v.r_addr1[0] = 5'd1; v.r_addr1[1] = 5'd1;
    v.rsv_valid[0] = 1'b1; v.rsv_addr[0] = 5'd6;
    r_valid1 = v.r_valid1; r_addr1 = v.r_addr1;
    rsv_valid = v.rsv_valid; rsv_addr = v.rsv_addr;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_output();
    @(posedge clk);
    #1;
    check_output();
    rst_n = 1'b1;
    v = idle_vec(); v.r_valid1[0] = 1'b1; v.r_addr1[0] = 5'd1;
    apply_stimulus(v);
    cmp("post-reset r1 data", rd_data1[0][0], 32'h0);
    cmp("post-reset r1 valid", {31'd0, rd_valid1[0][0]}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
